// File: rtl/weight_mem_loader_if.sv
// -----------------------------------------------------------------------------
// weight_mem_loader_if
//   Bundles the controller job handshake, the streamer valid/ready input and
//   both weight SRAM write ports of the weight memory loader.
//
//   Signal groups:
//     job     : start, mode_fc, base_addr, num_rows  (controller -> loader)
//               busy, done, checksum                 (loader -> controller)
//     stream  : in_data, in_valid                    (streamer -> loader)
//               in_ready                             (loader -> streamer)
//     sram    : wr_enable_cnn/wr_addr_cnn/wr_data_cnn (loader -> CNN port)
//               wr_enable_fc /wr_addr_fc /wr_data_fc  (loader -> FC port)
//
//   Modports:
//     master : the controller/streamer/SRAM side (testbench)
//     slave  : the loader itself
// -----------------------------------------------------------------------------
interface weight_mem_loader_if #(
    parameter int N_DIM_ARRAY       = 8,
    parameter int WEIGHT_DATA_WIDTH = 8,
    parameter int IN_WIDTH          = 32,
    parameter int ADDR_WIDTH        = 16
);
    logic                                       start;
    logic                                       mode_fc;
    logic [ADDR_WIDTH-1:0]                      base_addr;
    logic [ADDR_WIDTH-1:0]                      num_rows;
    logic [IN_WIDTH-1:0]                        in_data;
    logic                                       in_valid;
    logic                                       in_ready;
    logic                                       wr_enable_cnn;
    logic [ADDR_WIDTH-1:0]                      wr_addr_cnn;
    logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]   wr_data_cnn;
    logic                                       wr_enable_fc;
    logic [ADDR_WIDTH-1:0]                      wr_addr_fc;
    logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]   wr_data_fc;
    logic                                       busy;
    logic                                       done;
    logic [31:0]                                checksum;

    modport master (
        output start, mode_fc, base_addr, num_rows, in_data, in_valid,
        input  in_ready,
        input  wr_enable_cnn, wr_addr_cnn, wr_data_cnn,
        input  wr_enable_fc, wr_addr_fc, wr_data_fc,
        input  busy, done, checksum
    );

    modport slave (
        input  start, mode_fc, base_addr, num_rows, in_data, in_valid,
        output in_ready,
        output wr_enable_cnn, wr_addr_cnn, wr_data_cnn,
        output wr_enable_fc, wr_addr_fc, wr_data_fc,
        output busy, done, checksum
    );
endinterface

// File: rtl/weight_mem_loader.sv
// -----------------------------------------------------------------------------
// weight_mem_loader
//   Writer-side front end of the partitioned weight SRAM. Packed weight words
//   arriving on a valid/ready stream are assembled into full N_DIM_ARRAY-lane
//   rows and written to either the CNN or the FC write port at linearly
//   incrementing row addresses. A job is launched by a one-cycle start pulse
//   and finishes with a one-cycle done pulse.
//
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous, active-low reset
//     bus    : weight_mem_loader_if.slave (job handshake, input stream,
//              CNN/FC write ports, busy/done/checksum)
//
//   Build option:
//     WEIGHT_MEM_LOADER_CHECKSUM_EN - when defined, checksum is a 32-bit
//     wrapping sum of every written lane (unsigned). When undefined, checksum
//     is tied to 0 and no adder is built.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | waiting for start; stream not accepted
//   LOAD  | accepting beats, writing one row per BEATS accepted beats
//   DONE  | single-cycle completion; last row write strobe coincides
// -----------------------------------------------------------------------------
module weight_mem_loader #(
    parameter int N_DIM_ARRAY       = 8,
    parameter int WEIGHT_DATA_WIDTH = 8,
    parameter int IN_WIDTH          = 32,
    parameter int ADDR_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    weight_mem_loader_if.slave    bus
);

    localparam int ROW_W  = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
    localparam int BEATS  = ROW_W / IN_WIDTH;
    localparam int LPB    = IN_WIDTH / WEIGHT_DATA_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   mode_fc_q, mode_fc_d;
    logic [ADDR_WIDTH-1:0]  base_addr_q, base_addr_d;
    logic [ADDR_WIDTH-1:0]  row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0]  rows_left_q, rows_left_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0]       row_buf_q, row_buf_d;

    logic                   wr_en_cnn_q, wr_en_cnn_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_cnn_q, wr_addr_cnn_d;
    logic [ROW_W-1:0]       wr_data_cnn_q, wr_data_cnn_d;
    logic                   wr_en_fc_q, wr_en_fc_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_fc_q, wr_addr_fc_d;
    logic [ROW_W-1:0]       wr_data_fc_q, wr_data_fc_d;

    // row_full is the row buffer with the current beat merged in; it is what
    // gets written when the last beat of a row is accepted.
    logic [ROW_W-1:0]       row_full;
    logic                   row_wr;
    logic                   start_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            mode_fc_q     <= 1'b0;
            base_addr_q   <= '0;
            row_cnt_q     <= '0;
            rows_left_q   <= '0;
            beat_cnt_q    <= '0;
            row_buf_q     <= '0;
            wr_en_cnn_q   <= 1'b0;
            wr_addr_cnn_q <= '0;
            wr_data_cnn_q <= '0;
            wr_en_fc_q    <= 1'b0;
            wr_addr_fc_q  <= '0;
            wr_data_fc_q  <= '0;
        end else begin
            state_q       <= state_d;
            mode_fc_q     <= mode_fc_d;
            base_addr_q   <= base_addr_d;
            row_cnt_q     <= row_cnt_d;
            rows_left_q   <= rows_left_d;
            beat_cnt_q    <= beat_cnt_d;
            row_buf_q     <= row_buf_d;
            wr_en_cnn_q   <= wr_en_cnn_d;
            wr_addr_cnn_q <= wr_addr_cnn_d;
            wr_data_cnn_q <= wr_data_cnn_d;
            wr_en_fc_q    <= wr_en_fc_d;
            wr_addr_fc_q  <= wr_addr_fc_d;
            wr_data_fc_q  <= wr_data_fc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        mode_fc_d     = mode_fc_q;
        base_addr_d   = base_addr_q;
        row_cnt_d     = row_cnt_q;
        rows_left_d   = rows_left_q;
        beat_cnt_d    = beat_cnt_q;
        row_buf_d     = row_buf_q;
        wr_en_cnn_d   = 1'b0;
        wr_addr_cnn_d = wr_addr_cnn_q;
        wr_data_cnn_d = wr_data_cnn_q;
        wr_en_fc_d    = 1'b0;
        wr_addr_fc_d  = wr_addr_fc_q;
        wr_data_fc_d  = wr_data_fc_q;
        row_full      = row_buf_q;
        row_wr        = 1'b0;
        start_acc     = 1'b0;

        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt_q == BEAT_W'(b)) begin
                row_full[b*LPB*WEIGHT_DATA_WIDTH +: IN_WIDTH] = bus.in_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    start_acc   = 1'b1;
                    mode_fc_d   = bus.mode_fc;
                    base_addr_d = bus.base_addr;
                    rows_left_d = bus.num_rows;
                    row_cnt_d   = '0;
                    beat_cnt_d  = '0;
                    state_d     = (bus.num_rows != '0) ? LOAD : DONE;
                end
            end

            LOAD: begin
                if (bus.in_valid) begin
                    row_buf_d = row_full;
                    if (beat_cnt_q == LAST_BEAT) begin
                        row_wr      = 1'b1;
                        beat_cnt_d  = '0;
                        row_cnt_d   = row_cnt_q + 1'b1;
                        rows_left_d = rows_left_q - 1'b1;
                        // Address wraps modulo 2^ADDR_WIDTH by design.
                        if (mode_fc_q) begin
                            wr_en_fc_d   = 1'b1;
                            wr_addr_fc_d = base_addr_q + row_cnt_q;
                            wr_data_fc_d = row_full;
                        end else begin
                            wr_en_cnn_d   = 1'b1;
                            wr_addr_cnn_d = base_addr_q + row_cnt_q;
                            wr_data_cnn_d = row_full;
                        end
                        if (rows_left_q == ADDR_WIDTH'(1)) begin
                            state_d = DONE;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef WEIGHT_MEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;
    logic [31:0] lane_sum;

    always_comb begin
        lane_sum = '0;
        for (int k = 0; k < N_DIM_ARRAY; k++) begin
            lane_sum = lane_sum + 32'(row_full[k*WEIGHT_DATA_WIDTH +: WEIGHT_DATA_WIDTH]);
        end
        checksum_d = checksum_q;
        if (start_acc) begin
            checksum_d = '0;
        end else if (row_wr) begin
            checksum_d = checksum_q + lane_sum;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign bus.checksum = checksum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.in_ready      = (state_q == LOAD);
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = (state_q == DONE);
    assign bus.wr_enable_cnn = wr_en_cnn_q;
    assign bus.wr_addr_cnn   = wr_addr_cnn_q;
    assign bus.wr_data_cnn   = wr_data_cnn_q;
    assign bus.wr_enable_fc  = wr_en_fc_q;
    assign bus.wr_addr_fc    = wr_addr_fc_q;
    assign bus.wr_data_fc    = wr_data_fc_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
module tb_weight_mem_loader;

    typedef logic [31:0] beat_arr_t [8];

    logic clk = 1'b0;
    logic reset = 1'b0;

    weight_mem_loader_if bus ();

    weight_mem_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          wr_n;
    logic [15:0] rec_addr [8];
    logic [63:0] rec_data [8];
    bit          rec_fc   [8];
    int          rec_cyc  [8];
    int          ready_drop;
    int          done_cyc;
    int          beats_taken;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic fc, input logic [15:0] base, input logic [15:0] rows);
        bus.start     = 1'b1;
        bus.mode_fc   = fc;
        bus.base_addr = base;
        bus.num_rows  = rows;
        tick();
        bus.start     = 1'b0;
    endtask

    // Streams beats and logs every write strobe seen after each clock edge.
    task automatic drive_stream(input int nbeats, input beat_arr_t beats, input bit stall, input int max_cyc);
        int   idx;
        int   cyc;
        logic rdy;
        logic v;
        idx = 0;
        cyc = 0;
        wr_n = 0;
        ready_drop = 0;
        done_cyc = -1;
        while (idx < nbeats && cyc < max_cyc) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.in_valid = v;
            bus.in_data  = beats[idx];
            rdy = bus.in_ready;
            if (!rdy && !bus.done) ready_drop++;
            tick();
            if (rdy && v) idx++;
            if ((bus.wr_enable_cnn || bus.wr_enable_fc) && wr_n < 8) begin
                rec_fc[wr_n]   = bus.wr_enable_fc;
                rec_addr[wr_n] = bus.wr_enable_fc ? bus.wr_addr_fc : bus.wr_addr_cnn;
                rec_data[wr_n] = bus.wr_enable_fc ? bus.wr_data_fc : bus.wr_data_cnn;
                rec_cyc[wr_n]  = cyc;
                wr_n++;
            end
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            cyc++;
        end
        bus.in_valid = 1'b0;
        beats_taken = idx;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.wr_enable_cnn, bus.wr_enable_fc,
             bus.wr_addr_cnn, bus.wr_addr_fc, bus.wr_data_cnn, bus.wr_data_fc, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ready=%b busy=%b done=%b en_cnn=%b en_fc=%b, required all 0",
                     bus.in_ready, bus.busy, bus.done, bus.wr_enable_cnn, bus.wr_enable_fc);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_cnn_single();
        beat_arr_t b;
        b = '{default: '0};
        b[0] = 32'h04030201;
        b[1] = 32'h08070605;
        start_job(1'b0, 16'h0010, 16'd1);
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL cnn_load_state: ready=%b busy=%b, required 1 1", bus.in_ready, bus.busy);
        end
        drive_stream(2, b, 1'b0, 10);
        n_checks++;
        if (wr_n !== 1 || rec_fc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL cnn_write_count: writes=%0d fc=%b, required 1 0", wr_n, rec_fc[0]);
        end
        n_checks++;
        if (rec_addr[0] !== 16'h0010 || rec_data[0] !== 64'h0807060504030201) begin
            n_fail++;
            $display("FAIL cnn_write_row: addr=%h data=%h, required 0010 0807060504030201", rec_addr[0], rec_data[0]);
        end
        n_checks++;
        if (done_cyc !== rec_cyc[0] || bus.done !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cnn_done_coincide: done_cyc=%0d write_cyc=%0d done=%b ready=%b, required equal,1,0",
                     done_cyc, rec_cyc[0], bus.done, bus.in_ready);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.wr_enable_cnn !== 1'b0 ||
            bus.wr_data_cnn !== 64'h0807060504030201 || bus.wr_enable_fc !== 1'b0 || bus.wr_data_fc !== 64'h0) begin
            n_fail++;
            $display("FAIL cnn_after_done: done=%b busy=%b en=%b data=%h fc_en=%b fc_data=%h, required 0 0 0 0807060504030201 0 0",
                     bus.done, bus.busy, bus.wr_enable_cnn, bus.wr_data_cnn, bus.wr_enable_fc, bus.wr_data_fc);
        end
    endtask

    task automatic test_fc_stream();
        beat_arr_t b;
        logic [63:0] exp;
        for (int i = 0; i < 8; i++) begin
            b[i] = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)} ^ 32'hA0000000;
        end
        start_job(1'b1, 16'h0100, 16'd4);
        drive_stream(8, b, 1'b0, 20);
        n_checks++;
        if (wr_n !== 4 || ready_drop !== 0 || done_cyc !== 7) begin
            n_fail++;
            $display("FAIL fc_stream_shape: writes=%0d ready_drops=%0d done_cyc=%0d, required 4 0 7",
                     wr_n, ready_drop, done_cyc);
        end
        for (int r = 0; r < 4; r++) begin
            exp = {b[2*r+1], b[2*r]};
            n_checks++;
            if (rec_fc[r] !== 1'b1 || rec_addr[r] !== 16'(16'h0100 + r) || rec_data[r] !== exp || rec_cyc[r] !== 2*r+1) begin
                n_fail++;
                $display("FAIL fc_row%0d: fc=%b addr=%h data=%h cyc=%0d, required 1 %h %h %0d",
                         r, rec_fc[r], rec_addr[r], rec_data[r], rec_cyc[r], 16'(16'h0100 + r), exp, 2*r+1);
            end
        end
        tick();
    endtask

    task automatic test_stall_wrap();
        beat_arr_t b;
        b = '{default: '0};
        b[0] = 32'h33221100;
        b[1] = 32'h77665544;
        b[2] = 32'hBBAA9988;
        b[3] = 32'hFFEEDDCC;
        start_job(1'b0, 16'hFFFF, 16'd2);
        drive_stream(4, b, 1'b1, 200);
        n_checks++;
        if (beats_taken !== 4 || wr_n !== 2) begin
            n_fail++;
            $display("FAIL stall_counts: beats=%0d writes=%0d, required 4 2", beats_taken, wr_n);
        end
        n_checks++;
        if (rec_addr[0] !== 16'hFFFF || rec_data[0] !== 64'h7766554433221100 || rec_fc[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_row0: addr=%h data=%h fc=%b, required ffff 7766554433221100 0",
                     rec_addr[0], rec_data[0], rec_fc[0]);
        end
        n_checks++;
        if (rec_addr[1] !== 16'h0000 || rec_data[1] !== 64'hFFEEDDCCBBAA9988 || rec_fc[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_row1_wrap: addr=%h data=%h fc=%b, required 0000 ffeeddccbbaa9988 0",
                     rec_addr[1], rec_data[1], rec_fc[1]);
        end
        tick();
    endtask

    task automatic test_zero_rows();
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hDEADBEEF;
        start_job(1'b0, 16'h0040, 16'd0);
        n_checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0 ||
            bus.wr_enable_cnn !== 1'b0 || bus.wr_enable_fc !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rows_done: done=%b busy=%b ready=%b en_cnn=%b en_fc=%b, required 1 1 0 0 0",
                     bus.done, bus.busy, bus.in_ready, bus.wr_enable_cnn, bus.wr_enable_fc);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.wr_enable_cnn !== 1'b0 || bus.wr_enable_fc !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_rows_idle: done=%b busy=%b ready=%b en_cnn=%b en_fc=%b, required 0 0 0 0 0",
                     bus.done, bus.busy, bus.in_ready, bus.wr_enable_cnn, bus.wr_enable_fc);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_abort();
        beat_arr_t b;
        b = '{default: '0};
        b[0] = 32'h11111111;
        b[1] = 32'h22222222;
        b[2] = 32'h33333333;
        start_job(1'b0, 16'h0020, 16'd2);
        drive_stream(3, b, 1'b0, 10);
        n_checks++;
        if (wr_n !== 1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: writes=%0d busy=%b, required 1 1", wr_n, bus.busy);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.wr_enable_cnn, bus.wr_enable_fc,
             bus.wr_addr_cnn, bus.wr_addr_fc, bus.wr_data_cnn, bus.wr_data_fc, bus.checksum} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: ready=%b busy=%b addr=%h data=%h, required all 0",
                     bus.in_ready, bus.busy, bus.wr_addr_cnn, bus.wr_data_cnn);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        b[0] = 32'hCAFEF00D;
        b[1] = 32'h0BADBEEF;
        start_job(1'b0, 16'h0030, 16'd1);
        drive_stream(2, b, 1'b0, 10);
        n_checks++;
        if (wr_n !== 1 || rec_addr[0] !== 16'h0030 || rec_data[0] !== 64'h0BADBEEFCAFEF00D) begin
            n_fail++;
            $display("FAIL abort_next_job: writes=%0d addr=%h data=%h, required 1 0030 0badbeefcafef00d",
                     wr_n, rec_addr[0], rec_data[0]);
        end
        tick();
    endtask

    task automatic test_checksum();
        beat_arr_t b;
        logic [31:0] exp;
`ifdef WEIGHT_MEM_LOADER_CHECKSUM_EN
        exp = 32'h000003FD;
`else
        exp = 32'h00000000;
`endif
        b = '{default: '0};
        b[0] = 32'hFFFFFFFF;
        b[1] = 32'h00000001;
        start_job(1'b0, 16'h0000, 16'd1);
        drive_stream(2, b, 1'b0, 10);
        n_checks++;
        if (bus.checksum !== exp) begin
            n_fail++;
            $display("FAIL checksum_value: got %h, required %h", bus.checksum, exp);
        end
        tick();
        tick();
        n_checks++;
        if (bus.checksum !== exp) begin
            n_fail++;
            $display("FAIL checksum_hold: got %h, required %h", bus.checksum, exp);
        end
        start_job(1'b0, 16'h0000, 16'd0);
        n_checks++;
        if (bus.checksum !== 32'h0) begin
            n_fail++;
            $display("FAIL checksum_clear: got %h, required 00000000", bus.checksum);
        end
        tick();
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.mode_fc   = 1'b0;
        bus.base_addr = '0;
        bus.num_rows  = '0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        test_reset();
        test_cnn_single();
        test_fc_stream();
        test_stall_wrap();
        test_zero_rows();
        test_reset_abort();
        test_checksum();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
